// File: rtl/intr_resp_pkg.sv
// Shared types and constants for the interrupt acknowledge responder.
// Source indices follow the irq_i bit positions; PRIO_ORDER lists them highest first.
package intr_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2,
        SVC  = 2'd3
    } state_e;

    localparam int NUM_IRQ = 3;

    localparam int IRQ_EXT = 0;
    localparam int IRQ_TMR = 1;
    localparam int IRQ_SW  = 2;

    // external beats software beats timer
    localparam int PRIO_ORDER [NUM_IRQ] = '{IRQ_EXT, IRQ_SW, IRQ_TMR};

    function automatic int prio_src(input int rank);
        return PRIO_ORDER[rank];
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational priority encoder: picks the highest-priority asserted request as a one-hot grant.
// Zero latency; no backpressure. All-zero request gives all-zero grant.
module intr_prio_enc
    import intr_resp_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req_i,
    output logic [NUM_IRQ-1:0] grant_o
);

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        grant_o = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (req_i[prio_src(k)]) begin
                grant_o                = '0;
                grant_o[prio_src(k)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ack_resp.sv
// Interrupt responder: waits lat_cfg+1 cycles in PEND, emits a 1-cycle one-hot ack, then services svc_cfg+1 cycles.
// Latency from irq rise cycle t to ack is t+lat_cfg+2; irq is ignored outside IDLE/PEND, no backpressure.
module intr_ack_resp
    import intr_resp_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int CFG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mie_i,
    input  logic [CFG_W-1:0]           lat_cfg,
    input  logic [CFG_W-1:0]           svc_cfg,
    input  logic [NUM_IRQ-1:0]         irq_i,
    output logic [NUM_IRQ-1:0]         intr_ack_o,
    output logic                       in_service_o,
    output logic                       spurious_o,
    output logic [NUM_IRQ*CNT_W-1:0]   taken_cnt_o,
    output logic [CNT_W-1:0]           spurious_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CFG_W-1:0] CFG_ONE = CFG_W'(1);

    state_e                     state_q, state_d;
    logic [CFG_W-1:0]           lat_cnt_q, lat_cnt_d;
    logic [CFG_W-1:0]           svc_cnt_q, svc_cnt_d;
    logic [NUM_IRQ-1:0]         ack_q, ack_d;
    logic                       in_svc_q, in_svc_d;
    logic                       spur_q, spur_d;
    logic [NUM_IRQ*CNT_W-1:0]   taken_q, taken_d;
    logic [CNT_W-1:0]           spur_cnt_q, spur_cnt_d;

    logic [NUM_IRQ-1:0]         grant;
    logic                       pend;

    intr_prio_enc u_prio_enc (
        .req_i   (irq_i),
        .grant_o (grant)
    );

    assign pend = mie_i & (|irq_i);

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        svc_cnt_d  = svc_cnt_q;
        ack_d      = '0;
        spur_d     = 1'b0;
        taken_d    = taken_q;
        spur_cnt_d = spur_cnt_q;

        case (state_q)
            IDLE: begin
                if (pend) begin
                    state_d   = PEND;
                    lat_cnt_d = lat_cfg;
                end
            end
            PEND: begin
                if (!mie_i) begin
                    state_d = IDLE;
                end else if (irq_i == '0) begin
                    // source withdrew while enabled: count it, masking is not spurious
                    state_d = IDLE;
                    spur_d  = 1'b1;
                    if (spur_cnt_q != CNT_MAX) begin
                        spur_cnt_d = spur_cnt_q + CNT_ONE;
                    end
                end else if (lat_cnt_q == '0) begin
                    state_d = ACK;
                    ack_d   = grant;
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (grant[i] && (taken_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                            taken_d[i*CNT_W +: CNT_W] = taken_q[i*CNT_W +: CNT_W] + CNT_ONE;
                        end
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - CFG_ONE;
                end
            end
            ACK: begin
                state_d   = SVC;
                svc_cnt_d = svc_cfg;
            end
            SVC: begin
                if (svc_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    svc_cnt_d = svc_cnt_q - CFG_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_svc_d = (state_d == ACK) || (state_d == SVC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            svc_cnt_q  <= '0;
            ack_q      <= '0;
            in_svc_q   <= 1'b0;
            spur_q     <= 1'b0;
            taken_q    <= '0;
            spur_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            svc_cnt_q  <= svc_cnt_d;
            ack_q      <= ack_d;
            in_svc_q   <= in_svc_d;
            spur_q     <= spur_d;
            taken_q    <= taken_d;
            spur_cnt_q <= spur_cnt_d;
        end
    end

    assign intr_ack_o     = ack_q;
    assign in_service_o   = in_svc_q;
    assign spurious_o     = spur_q;
    assign taken_cnt_o    = taken_q;
    assign spurious_cnt_o = spur_cnt_q;

endmodule

// File: tb/tb_intr_ack_resp.sv
// Directed bench for intr_ack_resp: vector table for priority/latency, hand sequences for the corner cases.
module tb_intr_ack_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        mie_i;
    logic [3:0]  lat_cfg;
    logic [3:0]  svc_cfg;
    logic [2:0]  irq_i;

    logic [2:0]  ack, ack_s;
    logic        in_svc, in_svc_s;
    logic        spur, spur_s;
    logic [47:0] taken;
    logic [5:0]  taken_s;
    logic [15:0] spur_cnt;
    logic [1:0]  spur_cnt_s;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    intr_ack_resp #(.CNT_W(16), .CFG_W(4)) dut (
        .clk(clk), .rst(rst), .mie_i(mie_i), .lat_cfg(lat_cfg), .svc_cfg(svc_cfg),
        .irq_i(irq_i), .intr_ack_o(ack), .in_service_o(in_svc), .spurious_o(spur),
        .taken_cnt_o(taken), .spurious_cnt_o(spur_cnt)
    );

    intr_ack_resp #(.CNT_W(2), .CFG_W(4)) dut_sat (
        .clk(clk), .rst(rst), .mie_i(mie_i), .lat_cfg(lat_cfg), .svc_cfg(svc_cfg),
        .irq_i(irq_i), .intr_ack_o(ack_s), .in_service_o(in_svc_s), .spurious_o(spur_s),
        .taken_cnt_o(taken_s), .spurious_cnt_o(spur_cnt_s)
    );

    typedef struct {
        logic [2:0] irq;
        logic [3:0] lat;
        logic [2:0] exp_ack;
        int         exp_dly;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; irq_i = '0; mie_i = 1'b1;
        steps(2);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output int when, output logic [2:0] val);
        when = -1;
        val  = '0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (ack != '0) begin
                when = cyc;
                val  = ack;
                break;
            end
        end
        if (when < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack within %0d cycles, expected one (cycle %0d)", budget, cyc);
        end
    endtask

    vec_t tbl [8];

    initial begin
        int c0, when, acks, pulses, wide, nonhot, cloop_acks;
        logic [2:0] val, prev;

        tbl[0] = '{3'b001, 4'd3,  3'b001, 5};
        tbl[1] = '{3'b010, 4'd0,  3'b010, 2};
        tbl[2] = '{3'b100, 4'd1,  3'b100, 3};
        tbl[3] = '{3'b011, 4'd2,  3'b001, 4};
        tbl[4] = '{3'b110, 4'd0,  3'b100, 2};
        tbl[5] = '{3'b101, 4'd4,  3'b001, 6};
        tbl[6] = '{3'b111, 4'd15, 3'b001, 17};
        tbl[7] = '{3'b010, 4'd7,  3'b010, 9};

        rst = 1'b1; mie_i = 1'b0; irq_i = '0; lat_cfg = '0; svc_cfg = '0;
        step();
        check("reset_ack", ack, 0);
        check("reset_in_service", in_svc, 0);
        check("reset_spurious", spur, 0);
        check("reset_taken", taken, 0);
        check("reset_spur_cnt", spur_cnt, 0);

        // latency and priority vectors
        for (int v = 0; v < 8; v++) begin
            do_reset();
            svc_cfg = 4'd0;
            lat_cfg = tbl[v].lat;
            irq_i   = tbl[v].irq;
            c0 = cyc;
            wait_ack(40, when, val);
            check($sformatf("vec%0d_ack", v), val, tbl[v].exp_ack);
            check($sformatf("vec%0d_delay", v), when - c0, tbl[v].exp_dly);
            check($sformatf("vec%0d_in_service", v), in_svc, 1);
            step();
            check($sformatf("vec%0d_ack_width", v), ack, 0);
        end

        // single external irq with back-to-back re-arm
        do_reset();
        lat_cfg = 4'd3; svc_cfg = 4'd2;
        steps(3);
        irq_i = 3'b001;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("ext_ack_k%0d", k), ack, (k == 5 || k == 14) ? 3'b001 : 3'b000);
            check($sformatf("ext_insvc_k%0d", k), in_svc, ((k >= 5 && k <= 8) || k >= 14) ? 1'b1 : 1'b0);
            if (k == 14) check("ext_taken0", taken[15:0], 2);
        end

        // priority walk-down while losers remain pending
        do_reset();
        lat_cfg = 4'd0; svc_cfg = 4'd3;
        irq_i = 3'b111;
        wait_ack(20, when, val);
        check("prio_first", val, 3'b001);
        step();
        irq_i = 3'b110;
        wait_ack(20, when, val);
        check("prio_second", val, 3'b100);
        step();
        irq_i = 3'b010;
        wait_ack(20, when, val);
        check("prio_third", val, 3'b010);
        check("prio_taken", taken, {16'd1, 16'd1, 16'd1});

        // withdrawal by the source is spurious
        do_reset();
        lat_cfg = 4'd8; svc_cfg = 4'd0;
        irq_i = 3'b001;
        steps(4);
        irq_i = 3'b000;
        acks = 0; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack != '0) acks++;
            if (spur) pulses++;
        end
        check("wd_pulses", pulses, 1);
        check("wd_acks", acks, 0);
        check("wd_spur_cnt", spur_cnt, 1);

        // masking is not spurious
        irq_i = 3'b001;
        steps(4);
        mie_i = 1'b0;
        acks = 0; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack != '0) acks++;
            if (spur) pulses++;
        end
        check("mask_wd_pulses", pulses, 0);
        check("mask_wd_acks", acks, 0);
        check("mask_wd_spur_cnt", spur_cnt, 1);

        // global mask holds everything off, then release
        do_reset();
        mie_i = 1'b0; lat_cfg = 4'd2; svc_cfg = 4'd0;
        irq_i = 3'b111;
        acks = 0; pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (ack != '0) acks++;
            if (in_svc) pulses++;
        end
        check("mask_acks", acks, 0);
        check("mask_in_service", pulses, 0);
        mie_i = 1'b1;
        c0 = cyc;
        wait_ack(20, when, val);
        check("unmask_delay", when - c0, 4);
        check("unmask_ack", val, 3'b001);

        // reset during ACK
        do_reset();
        lat_cfg = 4'd0; svc_cfg = 4'd1;
        irq_i = 3'b001;
        wait_ack(20, when, val);
        check("rstack_taken_before", taken[15:0], 1);
        rst = 1'b1;
        step();
        check("rstack_ack", ack, 0);
        check("rstack_in_service", in_svc, 0);
        check("rstack_taken", taken, 0);
        rst = 1'b0;
        c0 = cyc;
        wait_ack(20, when, val);
        check("rstack_relat", when - c0, 2);

        // reset during PEND
        lat_cfg = 4'd5;
        for (int i = 0; i < 20 && in_svc; i++) step();
        step();
        check("rstpend_taken_before", taken[15:0], 1);
        rst = 1'b1;
        step();
        check("rstpend_ack", ack, 0);
        check("rstpend_in_service", in_svc, 0);
        check("rstpend_taken", taken, 0);
        check("rstpend_spur_cnt", spur_cnt, 0);
        rst = 1'b0;
        c0 = cyc;
        wait_ack(30, when, val);
        check("rstpend_relat", when - c0, 7);

        // saturation on the 2-bit build
        do_reset();
        lat_cfg = 4'd0; svc_cfg = 4'd0;
        irq_i = 3'b001;
        for (int i = 0; i < 5; i++) wait_ack(20, when, val);
        check("sat_narrow", taken_s[1:0], 3);
        check("sat_wide", taken[15:0], 5);
        steps(8);
        check("sat_narrow_hold", taken_s[1:0], 3);

        // closed loop against a random irq source
        do_reset();
        cloop_acks = 0; wide = 0; nonhot = 0; prev = '0;
        for (int i = 0; i < 30000 && cloop_acks < 200; i++) begin
            if ($urandom_range(0, 7) == 0) irq_i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) begin
                lat_cfg = 4'($urandom_range(0, 15));
                svc_cfg = 4'($urandom_range(0, 15));
            end
            mie_i = ($urandom_range(0, 19) != 0);
            step();
            if (ack != '0) begin
                cloop_acks++;
                if ($countones(ack) != 1) nonhot++;
                if (prev != '0) wide++;
            end
            prev = ack;
        end
        check("cl_no_hang", cloop_acks >= 200, 1);
        check("cl_wide_ack", wide, 0);
        check("cl_onehot", nonhot, 0);
        check("cl_taken_sum", 32'(taken[15:0]) + 32'(taken[31:16]) + 32'(taken[47:32]), cloop_acks);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
